fmmu_multi_map: RTL and testbench
=================================

FMMU_MULTI_MAP -- requirements
Module: fmmu_multi_map

Interface
REQ-001 SHALL have parameter NUM_FMMU, default 4, number of mapping channels (1..16).
REQ-002 SHALL have parameter LADDR_W, default 32, logical address width.
REQ-003 SHALL have parameter PADDR_W, default 16, physical address width.
REQ-004 SHALL have parameter LEN_W, default 11, datagram/channel length width in bytes.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- cfg_we  in  1  config write strobe.
- cfg_ready  out  1  config write accepted this cycle; high only in IDLE.
- cfg_idx  in  clog2(NUM_FMMU)  target channel.
- cfg_en  in  1  channel enable.
- cfg_log_start  in  LADDR_W  logical start.
- cfg_log_len  in  LEN_W  logical length.
- cfg_phys_start  in  PADDR_W  physical start.
- cfg_dir  in  2  bit0 read allowed, bit1 write allowed (FMMU_DIR_CHECK_EN only).
- req_valid / req_ready  in / out  1  datagram request handshake.
- req_addr  in  LADDR_W  datagram logical address.
- req_len  in  LEN_W  datagram length.
- req_write  in  1  1 = write datagram.
- map_valid / map_ready  out / in  1  mapping result handshake.
- map_idx  out  clog2(NUM_FMMU)  hitting channel.
- map_phys_addr  out  PADDR_W  physical start of the overlap.
- map_len  out  LEN_W  overlap length.
- map_offset  out  LEN_W  overlap start relative to req_addr.
- done  out  1  one-cycle pulse at the end of a request.

Function
REQ-006 SHALL implement the states IDLE, SCAN, EMIT and DONE; req_ready = cfg_ready = (state==IDLE).
REQ-007 SHALL, on an IDLE cycle with req_valid, latch req_addr, req_len and req_write, set the channel index to 0 and enter SCAN.
REQ-008 SHALL, in SCAN, evaluate one channel per cycle: lo = max(req_addr, ls), hi = min(req_addr+req_len, ls+ll), with sums computed at LADDR_W+1 bits (no wrap).
REQ-009 SHALL record a hit when the channel is enabled and hi > lo (a touching boundary is not a hit).
REQ-010 SHALL, on a hit, register map_phys_addr = phys_start + (lo-ls) (truncated to PADDR_W), map_len = hi-lo, map_offset = lo-req_addr and map_idx, and enter EMIT.
REQ-011 SHALL hold map_valid and all map_* outputs stable in EMIT until map_ready is high.
REQ-012 SHALL, after the EMIT handshake or after a miss, advance to the next channel, and after the last channel enter DONE.
REQ-013 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-014 SHALL give a latency of 1 cycle from request accept to map_valid when channel 0 hits, and of (k+1) cycles when the first hit is channel k.
REQ-015 SHALL complete a request with req_len = 0, or with no hit on any channel, with done only and no map_valid.
REQ-016 SHALL emit hits in ascending channel order, one result per hitting channel, including overlapping channels.
REQ-017 SHALL write the channel-cfg_idx registers on cfg_we && cfg_ready, ignore cfg_we outside IDLE, and ignore a cfg_idx >= NUM_FMMU.
REQ-018 SHALL accept a simultaneous cfg write and request in IDLE, with the scan using the newly written configuration.

Reset
REQ-019 SHALL, on RST, immediately clear the state to IDLE, all channel enables, config registers, map_* outputs, map_valid and done to 0.
REQ-020 SHALL, on RST mid-request, abandon the request without a done pulse.

Configuration
REQ-021 SHALL, with FMMU_DIR_CHECK_EN defined, store cfg_dir per channel and count a hit only if the direction bit matching req_write is set.
REQ-022 SHALL, without FMMU_DIR_CHECK_EN, not implement cfg_dir storage, leave cfg_dir unused, and match both directions.

Verification
REQ-023 SHALL cover a full-inside hit: ch0 {0x1000, 64, phys 0x0200}, req {0x1010, 16} -> map_phys 0x0210, len 16, offset 0, then done.
REQ-024 SHALL cover head and tail overlap: ch0 {0x1000, 32, 0x0200}, req {0x0FF0, 64} -> phys 0x0200, len 32, offset 16.
REQ-025 SHALL cover multi-hit with backpressure: ch1 {0x2000, 8, 0x0100}, ch3 {0x2008, 8, 0x0300}, req {0x2000, 16}, map_ready low for 5 cycles -> outputs stable, then ch1 (len 8, offset 0) and ch3 (len 8, offset 8) results, then done.
REQ-026 SHALL cover boundary and empty cases: req {0x0FE0, 32} against ch0 start 0x1000 -> no map_valid, done; req_len 0 -> done only.
REQ-027 SHALL cover the direction check: with FMMU_DIR_CHECK_EN, cfg_dir = 01 and a write request -> no hit; without the macro -> hit.
REQ-028 SHALL cover reset mid-EMIT: RST asserted -> map_valid 0 immediately, no done, next request served normally.

Source files
------------

// File: rtl/fmmu_multi_map.sv
// Logical-to-physical mapper: scans every channel for each datagram and emits one result per overlap.
// Optional per-channel direction filtering is compiled in with `define FMMU_DIR_CHECK_EN.
module fmmu_multi_map #(
  parameter int NUM_FMMU = 4,
  parameter int LADDR_W  = 32,
  parameter int PADDR_W  = 16,
  parameter int LEN_W    = 11,
  localparam int IDX_W   = (NUM_FMMU > 1) ? $clog2(NUM_FMMU) : 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               cfg_we,
  output logic               cfg_ready,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [LADDR_W-1:0] cfg_log_start,
  input  logic [LEN_W-1:0]   cfg_log_len,
  input  logic [PADDR_W-1:0] cfg_phys_start,
  input  logic [1:0]         cfg_dir,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               req_write,
  output logic               map_valid,
  input  logic               map_ready,
  output logic [IDX_W-1:0]   map_idx,
  output logic [PADDR_W-1:0] map_phys_addr,
  output logic [LEN_W-1:0]   map_len,
  output logic [LEN_W-1:0]   map_offset,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ch;
  logic [LADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]   r_len;
  logic               r_write;

  logic               w_en    [NUM_FMMU];
  logic [LADDR_W-1:0] w_ls    [NUM_FMMU];
  logic [LEN_W-1:0]   w_ll    [NUM_FMMU];
  logic [PADDR_W-1:0] w_ps    [NUM_FMMU];
  logic               w_cfg_wr;

  assign cfg_ready = (r_state == S_IDLE);
  assign req_ready = (r_state == S_IDLE);
  assign w_cfg_wr  = cfg_we && (r_state == S_IDLE) &&
                     ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_FMMU));

`ifdef FMMU_DIR_CHECK_EN
  logic [1:0] w_dir [NUM_FMMU];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FMMU; gi++) begin : g_ch
      logic               r_en;
      logic [LADDR_W-1:0] r_ls;
      logic [LEN_W-1:0]   r_ll;
      logic [PADDR_W-1:0] r_ps;
      always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
          r_en <= 1'b0;
          r_ls <= '0;
          r_ll <= '0;
          r_ps <= '0;
        end else if (w_cfg_wr && (cfg_idx == IDX_W'(gi))) begin
          r_en <= cfg_en;
          r_ls <= cfg_log_start;
          r_ll <= cfg_log_len;
          r_ps <= cfg_phys_start;
        end
      end
      assign w_en[gi] = r_en;
      assign w_ls[gi] = r_ls;
      assign w_ll[gi] = r_ll;
      assign w_ps[gi] = r_ps;
`ifdef FMMU_DIR_CHECK_EN
      logic [1:0] r_dir;
      always_ff @(posedge clk or posedge RST) begin
        if (RST)
          r_dir <= 2'b00;
        else if (w_cfg_wr && (cfg_idx == IDX_W'(gi)))
          r_dir <= cfg_dir;
      end
      assign w_dir[gi] = r_dir;
`endif
    end
  endgenerate

  logic w_dir_ok;
`ifdef FMMU_DIR_CHECK_EN
  assign w_dir_ok = r_write ? w_dir[r_ch][1] : w_dir[r_ch][0];
`else
  logic w_unused_dir;
  assign w_dir_ok     = 1'b1;
  assign w_unused_dir = ^{cfg_dir, r_write};
`endif

  // Interval ends are one bit wider than the address so a range ending at the top never wraps.
  logic [LADDR_W:0] w_req_end, w_ch_end, w_lo, w_hi, w_ovl, w_off, w_rel;
  logic             w_hit, w_last;

  assign w_req_end = {1'b0, r_addr} + (LADDR_W+1)'(r_len);
  assign w_ch_end  = {1'b0, w_ls[r_ch]} + (LADDR_W+1)'(w_ll[r_ch]);
  assign w_lo      = (r_addr > w_ls[r_ch]) ? {1'b0, r_addr} : {1'b0, w_ls[r_ch]};
  assign w_hi      = (w_req_end < w_ch_end) ? w_req_end : w_ch_end;
  assign w_hit     = w_en[r_ch] && (w_hi > w_lo) && w_dir_ok;
  assign w_ovl     = w_hi - w_lo;
  assign w_off     = w_lo - {1'b0, r_addr};
  assign w_rel     = w_lo - {1'b0, w_ls[r_ch]};
  assign w_last    = (r_ch == IDX_W'(NUM_FMMU - 1));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_ch          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_write       <= 1'b0;
      map_valid     <= 1'b0;
      map_idx       <= '0;
      map_phys_addr <= '0;
      map_len       <= '0;
      map_offset    <= '0;
      done          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_len   <= req_len;
            r_write <= req_write;
            r_ch    <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            map_valid     <= 1'b1;
            map_idx       <= r_ch;
            map_phys_addr <= w_ps[r_ch] + PADDR_W'(w_rel);
            map_len       <= LEN_W'(w_ovl);
            map_offset    <= LEN_W'(w_off);
            r_state       <= S_EMIT;
          end else if (w_last) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ch <= r_ch + IDX_W'(1);
          end
        end
        S_EMIT: begin
          if (map_ready) begin
            map_valid <= 1'b0;
            if (w_last) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ch    <= r_ch + IDX_W'(1);
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmmu_multi_map.sv
// Scoreboard bench for fmmu_multi_map: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_fmmu_multi_map;
  localparam int N  = 4;
  localparam int LW = 32;
  localparam int PW = 16;
  localparam int NW = 11;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          cfg_we = 1'b0, cfg_ready, cfg_en = 1'b0;
  logic [1:0]    cfg_idx = '0, cfg_dir = '0;
  logic [LW-1:0] cfg_log_start = '0;
  logic [NW-1:0] cfg_log_len = '0;
  logic [PW-1:0] cfg_phys_start = '0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [LW-1:0] req_addr = '0;
  logic [NW-1:0] req_len = '0;
  logic          map_valid, map_ready = 1'b1, done;
  logic [1:0]    map_idx;
  logic [PW-1:0] map_phys_addr;
  logic [NW-1:0] map_len, map_offset;

  fmmu_multi_map #(.NUM_FMMU(N), .LADDR_W(LW), .PADDR_W(PW), .LEN_W(NW)) dut (
    .clk(clk), .RST(RST), .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_log_start(cfg_log_start), .cfg_log_len(cfg_log_len),
    .cfg_phys_start(cfg_phys_start), .cfg_dir(cfg_dir), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len), .req_write(req_write),
    .map_valid(map_valid), .map_ready(map_ready), .map_idx(map_idx),
    .map_phys_addr(map_phys_addr), .map_len(map_len), .map_offset(map_offset), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int idx;
    int phys;
    int len;
    int off;
    int lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse and every valid map cycle is compared with the queue head.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (!RST) begin
        if (done) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL done_pulse: got unexpected done, required none");
          end else begin
            e = q.pop_front();
            if (!e.is_done) begin
              errors++;
              $display("FAIL done_pulse: got done, required map result idx=%0d", e.idx);
            end else
              $display("done pulse at cycle %0d", cyc);
          end
        end
        if (map_valid) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL map_result: got idx=%0d phys=%h, required nothing", map_idx, map_phys_addr);
          end else begin
            e  = q[0];
            ok = !e.is_done && int'(map_idx) == e.idx && int'(map_phys_addr) == e.phys &&
                 int'(map_len) == e.len && int'(map_offset) == e.off;
            if (!ok) begin
              errors++;
              $display("FAIL map_result: got idx=%0d phys=%h len=%0d off=%0d, required done=%0b idx=%0d phys=%h len=%0d off=%0d",
                       map_idx, map_phys_addr, map_len, map_offset, e.is_done, e.idx, e.phys, e.len, e.off);
            end
            if (map_ready) begin
              void'(q.pop_front());
              $display("map idx=%0d phys=%h len=%0d off=%0d", map_idx, map_phys_addr, map_len, map_offset);
              if (e.lat >= 0) begin
                checks++;
                if (cyc - acc_cyc != e.lat) begin
                  errors++;
                  $display("FAIL map_latency: got %0d cycles, required %0d", cyc - acc_cyc, e.lat);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic push_map(input int idx, input int phys, input int len, input int off, input int lat);
    exp_t e;
    e.is_done = 1'b0; e.idx = idx; e.phys = phys; e.len = len; e.off = off; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.idx = 0; e.phys = 0; e.len = 0; e.off = 0; e.lat = -1;
    q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL idle_wait: got req_ready=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic drive(input bit do_cfg, input int idx, input int en, input int ls, input int ll,
                       input int ps, input int dir, input bit do_req, input int addr,
                       input int len, input int wr);
    wait_ready();
    cfg_we = do_cfg; cfg_idx = 2'(idx); cfg_en = en[0]; cfg_log_start = LW'(ls);
    cfg_log_len = NW'(ll); cfg_phys_start = PW'(ps); cfg_dir = 2'(dir);
    req_valid = do_req; req_addr = LW'(addr); req_len = NW'(len); req_write = wr[0];
    @(posedge clk); #1;
    cfg_we = 1'b0; req_valid = 1'b0;
    if (do_req) acc_cyc = cyc;
  endtask

  task automatic cfg(input int idx, input int en, input int ls, input int ll, input int ps, input int dir);
    drive(1'b1, idx, en, ls, ll, ps, dir, 1'b0, 0, 0, 0);
  endtask

  task automatic req(input int addr, input int len, input int wr);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, addr, len, wr);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending items, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_map_valid();
    int n = 0;
    while (!map_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!map_valid) begin
      errors++;
      $display("FAIL map_valid_wait: got map_valid=0, required 1");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    checks++;
    if (map_valid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got valid=%b done=%b rdy=%b cfg_rdy=%b, required 0 0 1 1",
               map_valid, done, req_ready, cfg_ready);
    end

    // Full-inside hit, configured in the same cycle as the request.
    push_map(0, 'h0210, 16, 0, 1); push_done();
    drive(1'b1, 0, 1, 'h1000, 64, 'h0200, 3, 1'b1, 'h1010, 16, 0);
    wait_idle();

    // Request covers the whole channel with head and tail overhang.
    cfg(0, 1, 'h1000, 32, 'h0200, 3);
    push_map(0, 'h0200, 32, 16, 1); push_done();
    req('h0FF0, 64, 0);
    wait_idle();

    // Two hits under backpressure; a config write during the stall must be ignored.
    cfg(1, 1, 'h2000, 8, 'h0100, 3);
    cfg(3, 1, 'h2008, 8, 'h0300, 3);
    map_ready = 1'b0;
    push_map(1, 'h0100, 8, 0, -1); push_map(3, 'h0300, 8, 8, -1); push_done();
    req('h2000, 16, 0);
    wait_map_valid();
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ready_busy: got %b, required 0", cfg_ready);
    end
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_en = 1'b1; cfg_log_start = 'h2000;
    cfg_log_len = 16; cfg_phys_start = 'h0700; cfg_dir = 2'b11;
    @(posedge clk); #1 cfg_we = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    map_ready = 1'b1;
    wait_idle();

    push_map(1, 'h0100, 8, 0, 2); push_map(3, 'h0300, 8, 8, -1); push_done();
    req('h2000, 16, 0);
    wait_idle();

    // Touching boundary and zero-length request produce done only.
    push_done(); req('h0FE0, 32, 0); wait_idle();
    push_done(); req('h1010, 0, 0);  wait_idle();

    // Read-only channel against a write, then a read.
    cfg(0, 1, 'h1000, 32, 'h0200, 1);
`ifndef FMMU_DIR_CHECK_EN
    push_map(0, 'h0210, 16, 0, 1);
`endif
    push_done(); req('h1010, 16, 1); wait_idle();
    push_map(0, 'h0210, 16, 0, 1); push_done(); req('h1010, 16, 0); wait_idle();

    // Reset while a result is stalled in EMIT.
    map_ready = 1'b0;
    push_map(0, 'h0210, 16, 0, -1); push_done();
    req('h1010, 16, 0);
    wait_map_valid();
    @(posedge clk); #1 RST = 1'b1;
    #1;
    checks++;
    if (map_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_emit: got valid=%b done=%b, required 0 0", map_valid, done);
    end
    q.delete();
    repeat (2) begin @(posedge clk); #1; end
    RST = 1'b0; map_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got req_ready=%b, required 1", req_ready);
    end
    repeat (4) begin @(posedge clk); #1; end
    push_done(); req('h1010, 16, 0); wait_idle();
    cfg(0, 1, 'h1000, 64, 'h0200, 3);
    push_map(0, 'h0210, 16, 0, 1); push_done(); req('h1010, 16, 0); wait_idle();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
